// File: rtl/fpu_ss_offload_buffer.sv
// Offload request terminator and operand-capturing FIFO between the core's
// offload interface and the FPU decode/issue stage.
module fpu_ss_offload_buffer #(
    parameter int DEPTH   = 4,
    parameter int XLEN    = 32,
    parameter int INSTR_W = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic                         x_q_valid_i,
    output logic                         x_q_ready_o,
    input  logic [INSTR_W-1:0]           x_q_instr_i,
    input  logic [3*XLEN-1:0]            x_q_rs_i,
    input  logic [2:0]                   x_q_rs_valid_i,
    input  logic                         prd_accept_i,
    input  logic                         prd_writeback_i,
    input  logic                         prd_is_mem_op_i,
    input  logic [2:0]                   prd_use_rs_i,
    output logic                         x_k_accept_o,
    output logic                         x_k_writeback_o,
    output logic                         x_k_is_mem_op_o,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [INSTR_W-1:0]           out_instr_o,
    output logic [3*XLEN-1:0]            out_rs_o,
    output logic                         out_writeback_o,
    output logic                         out_is_mem_op_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    // Handshakes: a transfer happens on a cycle where valid and ready are both
    // high; a producer holds valid and payload stable until that cycle.

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [3*XLEN-1:0]  rs_mem    [DEPTH];
    logic [DEPTH-1:0]   wb_mem;
    logic [DEPTH-1:0]   mem_op_mem;

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;

    logic               rs_ok;
    logic               full;
    logic               push;
    logic               pop;
    logic [3*XLEN-1:0]  rs_masked;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign pop   = (count_q != '0) & out_ready_i;
    assign rs_ok = ((x_q_rs_valid_i & prd_use_rs_i) == prd_use_rs_i);

    // A full buffer still accepts when the head leaves in the same cycle,
    // which makes out_ready_i combinationally visible on x_q_ready_o.
    always_comb begin
        x_q_ready_o = 1'b0;
        if (rst_ni && !flush_i && x_q_valid_i) begin
            if (!prd_accept_i) begin
                x_q_ready_o = 1'b1;
            end else begin
                x_q_ready_o = rs_ok & (!full | pop);
            end
        end
    end

    assign push = x_q_valid_i & x_q_ready_o & prd_accept_i;

    assign x_k_accept_o    = x_q_valid_i & prd_accept_i & !flush_i;
    assign x_k_writeback_o = x_k_accept_o & prd_writeback_i;
    assign x_k_is_mem_op_o = x_k_accept_o & prd_is_mem_op_i;

    // Unused operands are stored as zero so downstream never sees stale data.
    always_comb begin
        rs_masked = '0;
        for (int i = 0; i < 3; i++) begin
            if (prd_use_rs_i[i]) begin
                rs_masked[i*XLEN +: XLEN] = x_q_rs_i[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Payload storage carries no reset; out_valid_o qualifies it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem[wr_ptr]  <= x_q_instr_i;
            rs_mem[wr_ptr]     <= rs_masked;
            wb_mem[wr_ptr]     <= prd_writeback_i;
            mem_op_mem[wr_ptr] <= prd_is_mem_op_i;
        end
    end

    assign out_valid_o     = (count_q != '0);
    assign out_instr_o     = instr_mem[rd_ptr];
    assign out_rs_o        = rs_mem[rd_ptr];
    assign out_writeback_o = wb_mem[rd_ptr];
    assign out_is_mem_op_o = mem_op_mem[rd_ptr];
    assign count_o         = count_q;

endmodule
